// File: rtl/read_bmap_row.sv
// Bitmap row fetch engine: issues pipelined 32-bit word reads for a run of
// 16-bit pixels and streams the unpacked pixels out in x order.
module read_bmap_row #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int PIXEL_WIDTH = 16,
    parameter int PIPE_LEN    = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   req,
    input  logic [ADDR_WIDTH-1:0]  fb_base_in,
    input  logic [31:0]            wmod_in,
    input  logic signed [31:0]     xcur_in,
    input  logic signed [31:0]     ycur_in,
    input  logic signed [31:0]     cnt_in,
    output logic                   mem_rd,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   pix_req,
    output logic [PIXEL_WIDTH-1:0] pixel,
    input  logic                   pix_resp,
    output logic                   busy
);
    localparam int PW = $clog2(PIPE_LEN);
    localparam int CW = PW + 1;
    localparam logic [CW:0] PIPE_LIM = (CW + 1)'(PIPE_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           words_left_r;
    logic [31:0]           pix_left_r;
    logic                  lane_r;
    logic                  busy_r;
    logic [CW-1:0]         outst_r;
    logic [CW-1:0]         fifo_cnt_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [DATA_WIDTH-1:0] fifo_r [PIPE_LEN];

    logic [31:0]           n_s;
    logic [31:0]           prod_s;
    logic [ADDR_WIDTH-1:0] start_s;
    logic [31:0]           nwords_s;
    logic [CW:0]           credit_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  run_s;
    logic                  issue_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  avail_s;
    logic                  xfer_s;
    logic                  last_s;
    logic                  pop_s;

    // Request decode and per-cycle handshake qualifiers.
    always_comb begin
        n_s      = (cnt_in > 32'sd0) ? $unsigned(cnt_in) : 32'd0;
        prod_s   = ycur_in * wmod_in;
        start_s  = fb_base_in + ADDR_WIDTH'(prod_s) + ADDR_WIDTH'($unsigned(xcur_in) << 1);
        nwords_s = 32'(({32'd0, start_s[1]} + {1'b0, n_s} + 33'd1) >> 1);
        run_s    = (state_r == S_RUN);
        credit_s = {1'b0, outst_r} + {1'b0, fifo_cnt_r};
        // Outstanding reads are counted against FIFO space so a response always has a slot.
        issue_s  = run_s && (words_left_r != 32'd0) && (credit_s < PIPE_LIM);
        accept_s = issue_s && mem_ready;
        push_s   = run_s && mem_rvalid;
        avail_s  = run_s && (fifo_cnt_r != {CW{1'b0}});
        xfer_s   = avail_s && pix_resp;
        last_s   = xfer_s && (pix_left_r == 32'd1);
        pop_s    = xfer_s && (lane_r || (pix_left_r == 32'd1));
        head_s   = fifo_r[rd_ptr_r];
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: begin
                if (req) begin
                    state_nx = (n_s == 32'd0) ? S_DONE : S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_RUN;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register, issue address/counters, unpacker lane and busy flag.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r      <= S_IDLE;
            busy_r       <= 1'b0;
            addr_r       <= {ADDR_WIDTH{1'b0}};
            words_left_r <= 32'd0;
            pix_left_r   <= 32'd0;
            lane_r       <= 1'b0;
            outst_r      <= {CW{1'b0}};
        end else begin
            state_r <= state_nx;
            case (state_r)
                S_IDLE: begin
                    if (req) begin
                        busy_r       <= 1'b1;
                        addr_r       <= start_s & ~ADDR_WIDTH'(3);
                        words_left_r <= nwords_s;
                        pix_left_r   <= n_s;
                        lane_r       <= start_s[1];
                        outst_r      <= {CW{1'b0}};
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept_s) begin
                        addr_r       <= addr_r + ADDR_WIDTH'(4);
                        words_left_r <= words_left_r - 32'd1;
                    end
                    if (accept_s && !push_s) begin
                        outst_r <= outst_r + CW'(1);
                    end else if (!accept_s && push_s) begin
                        outst_r <= outst_r - CW'(1);
                    end
                    if (xfer_s) begin
                        pix_left_r <= pix_left_r - 32'd1;
                        lane_r     <= !pop_s;
                    end
                    if (last_s) begin
                        busy_r <= 1'b0;
                    end
                end
                S_DONE:  busy_r <= 1'b0;
                default: busy_r <= 1'b0;
            endcase
        end
    end

    // Word FIFO between the memory response port and the unpacker.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
            for (int i = 0; i < PIPE_LEN; i++) begin
                fifo_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if ((state_r == S_IDLE) && req) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= mem_rdata;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (push_s && !pop_s) begin
                fifo_cnt_r <= fifo_cnt_r + CW'(1);
            end else if (!push_s && pop_s) begin
                fifo_cnt_r <= fifo_cnt_r - CW'(1);
            end
        end
    end

    // Outputs are decoded from registered state only; all zero outside RUN.
    assign mem_rd   = issue_s;
    assign mem_addr = run_s ? addr_r : {ADDR_WIDTH{1'b0}};
    assign pix_req  = avail_s;
    assign pixel    = !avail_s ? {PIXEL_WIDTH{1'b0}}
                    : (lane_r ? head_s[2*PIXEL_WIDTH-1:PIXEL_WIDTH] : head_s[PIXEL_WIDTH-1:0]);
    assign busy     = busy_r;

endmodule

// File: tb/tb_read_bmap_row.sv
// Self-checking bench for read_bmap_row: randomized memory/consumer timing,
// expected reads and pixels derived per pixel from its byte address.
module tb_read_bmap_row;
    localparam int PIPE = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req;
    logic [31:0] fb_base_in;
    logic [31:0] wmod_in;
    logic signed [31:0] xcur_in;
    logic signed [31:0] ycur_in;
    logic signed [31:0] cnt_in;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        pix_req;
    logic [15:0] pixel;
    logic        pix_resp;
    logic        busy;

    always #5 aclk = ~aclk;

    read_bmap_row #(.PIPE_LEN(PIPE)) dut (
        .aclk(aclk), .aresetn(aresetn), .req(req),
        .fb_base_in(fb_base_in), .wmod_in(wmod_in),
        .xcur_in(xcur_in), .ycur_in(ycur_in), .cnt_in(cnt_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .pix_req(pix_req), .pixel(pixel), .pix_resp(pix_resp), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1, ready_pct = 100, resp_pct = 100, resp_hold = 0, resp_until = 0;
    bit scramble = 1'b0;

    int          due_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] got_reads[$], exp_reads[$];
    logic [15:0] got_pix[$], exp_pix[$];

    int   n_cur = 0, lane0_cur = 0;
    int   busy_cycles, max_occ, stab_err, first_pix_cyc, first_rd_cyc, req_edge, last_xfer_cyc;
    logic busy_after_last;
    bit   timeout, stall_prev;
    logic [31:0] stall_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return scramble ? ((a * 32'h9E37_79B1) ^ 32'h1234_5678) : a;
    endfunction

    // Reference: pixel i lives at byte A0 + 2i; its word and half follow directly.
    task automatic build_model(input logic [31:0] base, input logic [31:0] wmod,
                               input int x, input int y, input int cnt);
        logic [31:0] a0, a, w, wv, yv;
        int n;
        yv = 32'(y);
        a0 = base + yv * wmod + 32'(2 * x);
        n  = (cnt > 0) ? cnt : 0;
        exp_reads.delete();
        exp_pix.delete();
        for (int i = 0; i < n; i++) begin
            a  = a0 + 32'(2 * i);
            w  = a & 32'hFFFF_FFFC;
            wv = mem_word(w);
            if (exp_reads.size() == 0 || exp_reads[$] != w) exp_reads.push_back(w);
            exp_pix.push_back(a[1] ? wv[31:16] : wv[15:0]);
        end
        n_cur     = n;
        lane0_cur = int'(a0[1]);
    endtask

    // One clock: observe, drive memory responder and consumer, advance to next negedge.
    task automatic step();
        int done_words, occ;
        done_words = (got_pix.size() >= n_cur) ? exp_reads.size() : (lane0_cur + got_pix.size()) / 2;
        occ = got_reads.size() - done_words;
        if (occ > max_occ) max_occ = occ;
        if (busy === 1'b1) busy_cycles++;
        if (cyc == last_xfer_cyc) busy_after_last = busy;
        if (pix_req === 1'b1 && first_pix_cyc < 0) first_pix_cyc = cyc;
        if (mem_rd === 1'b1 && first_rd_cyc < 0) first_rd_cyc = cyc;
        if (stall_prev && mem_rd === 1'b1 && mem_addr !== stall_addr) stab_err++;
        if (!aresetn) begin
            due_q.delete();
            dat_q.delete();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end else if (due_q.size() > 0 && due_q[0] == cyc + 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dat_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        mem_ready = (($urandom % 100) < ready_pct);
        if (aresetn && mem_rd === 1'b1 && mem_ready) begin
            got_reads.push_back(mem_addr);
            due_q.push_back(cyc + 1 + lat);
            dat_q.push_back(mem_word(mem_addr));
        end
        stall_prev = (mem_rd === 1'b1) && !mem_ready;
        stall_addr = mem_addr;
        pix_resp = (cyc >= resp_until) && (($urandom % 100) < resp_pct);
        if (aresetn && pix_req === 1'b1 && pix_resp) begin
            got_pix.push_back(pixel);
            if (got_pix.size() == n_cur) last_xfer_cyc = cyc + 1;
        end
        @(negedge aclk);
        cyc++;
    endtask

    task automatic run_op(input logic [31:0] base, input logic [31:0] wmod,
                          input int x, input int y, input int cnt, input int rst_pix);
        int k;
        build_model(base, wmod, x, y, cnt);
        got_reads.delete();
        got_pix.delete();
        busy_cycles = 0; max_occ = 0; stab_err = 0;
        first_pix_cyc = -1; first_rd_cyc = -1; last_xfer_cyc = -1;
        busy_after_last = 1'b1; timeout = 1'b0; stall_prev = 1'b0;
        fb_base_in = base; wmod_in = wmod; xcur_in = x; ycur_in = y; cnt_in = cnt;
        req = 1'b1;
        req_edge   = cyc + 1;
        resp_until = req_edge + resp_hold;
        step();
        req = 1'b0;
        fb_base_in = $urandom; wmod_in = $urandom; xcur_in = $urandom; ycur_in = $urandom; cnt_in = $urandom;
        for (k = 0; k < 3000; k++) begin
            if (rst_pix >= 0 && got_pix.size() == rst_pix && pix_req === 1'b1) begin
                aresetn = 1'b0;
                step();
                aresetn = 1'b1;
                return;
            end
            if (busy_cycles > 0 && busy === 1'b0 && got_pix.size() >= n_cur) break;
            step();
        end
        if (k >= 3000) timeout = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        aresetn = 1'b0; req = 1'b0; fb_base_in = 32'h0; wmod_in = 32'h0;
        xcur_in = 0; ycur_in = 0; cnt_in = 0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0; pix_resp = 1'b0;
        repeat (2) step();
        aresetn = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b want 0", mem_rd); end
        checks++; if (pix_req !== 1'b0) begin errors++; $display("FAIL reset_pix_req got %b want 0", pix_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (pixel !== 16'h0) begin errors++; $display("FAIL reset_pixel got %h want 0", pixel); end
    endtask

    task automatic test_aligned();
        lat = 1; ready_pct = 100; resp_pct = 100; resp_hold = 0; scramble = 1'b0;
        run_op(32'h0, 32'h500, 10, 10, 10, -1);
        checks++; if (timeout) begin errors++; $display("FAIL aligned_done got timeout want completion"); end
        checks++; if (got_reads.size() != 5) begin errors++; $display("FAIL aligned_nreads got %0d want 5", got_reads.size()); end
        for (int i = 0; i < got_reads.size() && i < 5; i++) begin
            checks++;
            if (got_reads[i] !== 32'h3214 + 32'(4 * i)) begin
                errors++; $display("FAIL aligned_read%0d got %h want %h", i, got_reads[i], 32'h3214 + 32'(4 * i));
            end
        end
        checks++; if (got_pix.size() != 10) begin errors++; $display("FAIL aligned_npix got %0d want 10", got_pix.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
            checks++;
            if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL aligned_pix%0d got %h want %h", i, got_pix[i], exp_pix[i]); end
        end
        checks++; if (busy_after_last !== 1'b0) begin errors++; $display("FAIL aligned_busy_fall got %b want 0", busy_after_last); end
        checks++; if (first_rd_cyc != req_edge) begin errors++; $display("FAIL aligned_rd_latency got %0d want %0d", first_rd_cyc, req_edge); end
        checks++; if (first_pix_cyc != req_edge + 1 + lat) begin errors++; $display("FAIL aligned_pix_latency got %0d want %0d", first_pix_cyc, req_edge + 1 + lat); end
    endtask

    task automatic test_odd_start();
        lat = 1; ready_pct = 100; resp_pct = 100; resp_hold = 0; scramble = 1'b1;
        run_op(32'h0, 32'h500, 11, 10, 1, -1);
        checks++; if (got_reads.size() != 1 || got_reads[0] !== 32'h3214) begin
            errors++; $display("FAIL odd1_reads got %0d reads first %h want 1 read at 3214", got_reads.size(), (got_reads.size() > 0) ? got_reads[0] : 32'h0);
        end
        checks++; if (got_pix.size() != 1 || got_pix[0] !== exp_pix[0]) begin
            errors++; $display("FAIL odd1_pixel got %0d pixels first %h want 1 pixel %h", got_pix.size(), (got_pix.size() > 0) ? got_pix[0] : 16'h0, exp_pix[0]);
        end
        checks++; if (busy_after_last !== 1'b0) begin errors++; $display("FAIL odd1_busy_fall got %b want 0", busy_after_last); end
        run_op(32'h0, 32'h500, 11, 10, 4, -1);
        checks++; if (got_reads.size() != 3) begin errors++; $display("FAIL odd4_nreads got %0d want 3", got_reads.size()); end
        for (int i = 0; i < got_reads.size() && i < 3; i++) begin
            checks++;
            if (got_reads[i] !== 32'h3214 + 32'(4 * i)) begin
                errors++; $display("FAIL odd4_read%0d got %h want %h", i, got_reads[i], 32'h3214 + 32'(4 * i));
            end
        end
        checks++; if (got_pix.size() != 4) begin errors++; $display("FAIL odd4_npix got %0d want 4", got_pix.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
            checks++;
            if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL odd4_pix%0d got %h want %h", i, got_pix[i], exp_pix[i]); end
        end
    endtask

    task automatic test_backpressure();
        lat = 2; ready_pct = 70; resp_pct = 100; resp_hold = 20; scramble = 1'b1;
        run_op(32'h0, 32'h500, 10, 10, 16, -1);
        resp_hold = 0;
        checks++; if (timeout) begin errors++; $display("FAIL bp_done got timeout want completion"); end
        checks++; if (max_occ != PIPE) begin errors++; $display("FAIL bp_occupancy got peak %0d want %0d", max_occ, PIPE); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_addr_stable got %0d violations want 0", stab_err); end
        checks++; if (got_reads.size() != exp_reads.size()) begin errors++; $display("FAIL bp_nreads got %0d want %0d", got_reads.size(), exp_reads.size()); end
        for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++) begin
            checks++;
            if (got_reads[i] !== exp_reads[i]) begin errors++; $display("FAIL bp_read%0d got %h want %h", i, got_reads[i], exp_reads[i]); end
        end
        checks++; if (got_pix.size() != exp_pix.size()) begin errors++; $display("FAIL bp_npix got %0d want %0d", got_pix.size(), exp_pix.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
            checks++;
            if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL bp_pix%0d got %h want %h", i, got_pix[i], exp_pix[i]); end
        end
    endtask

    task automatic test_zero_count();
        int counts [2] = '{0, -5};
        lat = 1; ready_pct = 100; resp_pct = 100; resp_hold = 0;
        foreach (counts[j]) begin
            run_op(32'h0, 32'h500, 10, 10, counts[j], -1);
            checks++; if (busy_cycles != 1) begin errors++; $display("FAIL zero%0d_busy got %0d cycles want 1", j, busy_cycles); end
            checks++; if (got_reads.size() != 0) begin errors++; $display("FAIL zero%0d_reads got %0d want 0", j, got_reads.size()); end
            checks++; if (got_pix.size() != 0) begin errors++; $display("FAIL zero%0d_pixels got %0d want 0", j, got_pix.size()); end
        end
    endtask

    task automatic test_reset_mid();
        lat = 1; ready_pct = 100; resp_pct = 100; resp_hold = 0; scramble = 1'b0;
        run_op(32'h0, 32'h500, 10, 10, 10, 2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rstmid_mem_rd got %b want 0", mem_rd); end
        checks++; if (pix_req !== 1'b0) begin errors++; $display("FAIL rstmid_pix_req got %b want 0", pix_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_mem_addr got %h want 0", mem_addr); end
        checks++; if (pixel !== 16'h0) begin errors++; $display("FAIL rstmid_pixel got %h want 0", pixel); end
        scramble = 1'b1;
        run_op(32'h0, 32'h500, 0, 0, 2, -1);
        checks++; if (timeout) begin errors++; $display("FAIL rstmid_redo got timeout want completion"); end
        checks++; if (got_reads.size() != 1 || got_reads[0] !== 32'h0) begin
            errors++; $display("FAIL rstmid_reads got %0d reads first %h want 1 read at 0", got_reads.size(), (got_reads.size() > 0) ? got_reads[0] : 32'hFFFF_FFFF);
        end
        checks++; if (got_pix.size() != 2) begin errors++; $display("FAIL rstmid_npix got %0d want 2", got_pix.size()); end
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
            checks++;
            if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL rstmid_pix%0d got %h want %h", i, got_pix[i], exp_pix[i]); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 9; t++) begin
            logic [31:0] base, wmod;
            int x, y, cnt;
            lat = $urandom_range(1, 4); ready_pct = $urandom_range(30, 100);
            resp_pct = $urandom_range(30, 100); resp_hold = $urandom_range(0, 10); scramble = 1'b1;
            base = $urandom & 32'hFFFF_FFFC;
            wmod = 32'($urandom_range(0, 4096) * 2);
            x = $urandom_range(0, 300); y = $urandom_range(0, 100); cnt = $urandom_range(1, 40);
            if (t == 0) begin
                base = 32'hFFFF_FFF8; x = 0; y = 0; cnt = 12;
            end
            run_op(base, wmod, x, y, cnt, -1);
            checks++; if (timeout) begin errors++; $display("FAIL rnd%0d_done got timeout want completion", t); end
            checks++; if (max_occ > PIPE || stab_err != 0) begin
                errors++; $display("FAIL rnd%0d_credit got peak %0d stall_errs %0d want peak<=%0d errs 0", t, max_occ, stab_err, PIPE);
            end
            checks++; if (got_reads.size() != exp_reads.size()) begin errors++; $display("FAIL rnd%0d_nreads got %0d want %0d", t, got_reads.size(), exp_reads.size()); end
            for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++) begin
                checks++;
                if (got_reads[i] !== exp_reads[i]) begin errors++; $display("FAIL rnd%0d_read%0d got %h want %h", t, i, got_reads[i], exp_reads[i]); end
            end
            checks++; if (got_pix.size() != exp_pix.size()) begin errors++; $display("FAIL rnd%0d_npix got %0d want %0d", t, got_pix.size(), exp_pix.size()); end
            for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
                checks++;
                if (got_pix[i] !== exp_pix[i]) begin errors++; $display("FAIL rnd%0d_pix%0d got %h want %h", t, i, got_pix[i], exp_pix[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_odd_start();
        test_backpressure();
        test_zero_count();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
